signed_addsub_serial: RTL and testbench
=======================================

Name: signed_addsub_serial

Overview:
- Multi-cycle, parametrised signed adder/subtractor with valid/ready handshakes on input and output.
- Processes operands STEP bits per cycle, LSB chunk first, so one narrow adder serves any SIZE.
- Returns three things: the exact SIZE+1-bit two's-complement result, a SIZE-bit wrapped or saturated result, and an overflow flag.
- Sits in the ALU datapath where a full-width single-cycle signed adder costs too much area or timing.

Parameters:
- SIZE, 8, operand width in bits (two's complement); must be >= 2.
- STEP, 4, bits added per cycle; 1 <= STEP <= SIZE and SIZE % STEP == 0; N = SIZE/STEP compute cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept an operation (high only in IDLE).
- a  input  SIZE  signed operand A.
- b  input  SIZE  signed operand B.
- sub  input  1  0: A+B, 1: A-B.
- saturate  input  1  1: sat_result clamps on overflow; 0: sat_result wraps.
- out_valid  output  1  results valid.
- out_ready  input  1  consumer accepts results.
- result  output  SIZE+1  exact signed A±B; never overflows.
- sat_result  output  SIZE  SIZE-bit result, wrapped or clamped per captured saturate.
- overflow  output  1  exact result does not fit in SIZE signed bits.

Behaviour:
- Reset (async, any state):
  - state=IDLE, in_ready=1, out_valid=0.
  - result, sat_result, overflow all 0.
  - Internal operand, carry and chunk-index registers cleared.
  - Reset mid-RUN or mid-DONE aborts the operation; nothing is emitted afterwards.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready:
    - Capture a.
    - Capture b_eff = sub ? ~b : b.
    - Capture carry = sub.
    - Capture saturate; chunk index k=0; go to RUN.
  - Inputs are sampled only at the accept edge.
- RUN:
  - in_ready=0.
  - Each edge adds a[k*STEP +: STEP] + b_eff[k*STEP +: STEP] + carry, stores the STEP sum bits into result[k*STEP +: STEP] and the carry-out into carry, then increments k.
  - The edge processing k=N-1 also:
    - Sets result[SIZE] = a[SIZE-1] ^ b_eff[SIZE-1] ^ carry_out.
    - Sets overflow = result[SIZE] ^ result[SIZE-1].
    - Sets sat_result:
      - No overflow, or saturate=0: sat_result = result[SIZE-1:0].
      - Overflow with saturate=1 and result[SIZE]=1: sat_result = 1 followed by SIZE-1 zeros (most negative value).
      - Overflow with saturate=1 and result[SIZE]=0: sat_result = 0 followed by SIZE-1 ones (most positive value).
    - Goes to DONE.
  - result, overflow and sat_result are not meaningful while out_valid=0.
- Latency:
  - Accept at edge T; out_valid rises after edge T+N.
  - STEP=SIZE gives single-cycle compute, N=1.
- DONE:
  - out_valid=1, in_ready=0.
  - All outputs are held stable while out_ready=0, for any number of cycles.
  - On an edge with out_valid&&out_ready: out_valid=0, state=IDLE.
  - Outputs keep their last values until the next completion.
- Throughput: one operation per N+2 cycles minimum (accept, N compute, drain). No overlap of a new accept with DONE; an in_valid held during DONE/RUN is not accepted until IDLE.
- Width rules:
  - Full result is the sign-extended SIZE+1-bit sum.
  - Subtraction uses invert-plus-carry-in. With the extended sign bit of ~b this is exact, including b = most negative value.
- out_ready is ignored outside DONE.

Test Plan (SIZE=8, STEP=4 unless stated):
1. a=0x7F, b=0x01, sub=0, saturate=0 -> out_valid after 2 edges; result=9'h080, overflow=1, sat_result=0x80. Repeat with saturate=1 -> sat_result=0x7F.
2. a=0x80, b=0x01, sub=1, saturate=1 -> result=9'h17F (-129), overflow=1, sat_result=0x80. Then a=0x00, b=0x80, sub=1 -> result=9'h080 (+128), overflow=1, sat_result=0x7F.
3. a=0xFB (-5), b=0x03, sub=0 -> result=9'h1FE, overflow=0, sat_result=0xFE. Then a=0x05, b=0x05, sub=1 -> result=0, overflow=0.
4. Backpressure: complete an op, hold out_ready=0 for 5 cycles with in_valid=1 and new operands. Required: outputs stable, in_ready=0, no accept. Raise out_ready: out_valid drops next edge, in_ready=1, new op accepted on the following edge.
5. Assert rst asynchronously mid-RUN (after first chunk). Required: out_valid=0, in_ready=1 and outputs 0 immediately, without waiting for a clock edge; no out_valid pulse appears afterwards. The next op runs correctly.
6. STEP=1 build: a=0x80, b=0x80, sub=0 -> out_valid after 8 edges; result=9'h100, overflow=1. STEP=8 build: same op -> out_valid after 1 edge, identical outputs.

Source files
------------

// File: rtl/signed_addsub_serial.sv
// Digit-serial signed adder/subtractor: STEP bits per cycle, LSB chunk first,
// producing the exact SIZE+1-bit result, a wrapped/saturated SIZE-bit result and an overflow flag.
module signed_addsub_serial #(
    parameter int SIZE = 8,
    parameter int STEP = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [SIZE-1:0] a,
    input  logic signed [SIZE-1:0] b,
    input  logic                   sub,
    input  logic                   saturate,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [SIZE:0]   result,
    output logic signed [SIZE-1:0] sat_result,
    output logic                   overflow
);

    localparam int N  = SIZE / STEP;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state, state_nxt;
    logic signed [SIZE-1:0] a_q, b_q;
    logic                   carry_q, sat_q;
    logic [KW-1:0]          k_q;
    logic signed [SIZE:0]   result_q;
    logic signed [SIZE-1:0] sat_result_q;
    logic                   overflow_q;

    logic                   last;
    int unsigned            base;
    logic [STEP:0]          sum;
    logic [SIZE:0]          res_nxt;
    logic                   ovf_nxt;

    // Clamp toward the sign of the exact result when it does not fit in SIZE bits.
    function automatic logic [SIZE-1:0] sat_fn(input logic [SIZE:0] r, input logic en);
        if (en && (r[SIZE] ^ r[SIZE-1]))
            return r[SIZE] ? {1'b1, {(SIZE-1){1'b0}}} : {1'b0, {(SIZE-1){1'b1}}};
        return r[SIZE-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // One chunk of the ripple: carry_q links successive chunks across cycles.
    always_comb begin
        last    = (k_q == KW'(N - 1));
        base    = int'(k_q) * STEP;
        sum     = {1'b0, a_q[base +: STEP]} + {1'b0, b_q[base +: STEP]} + {{STEP{1'b0}}, carry_q};
        res_nxt = result_q;
        res_nxt[base +: STEP] = sum[STEP-1:0];
        if (last) res_nxt[SIZE] = a_q[SIZE-1] ^ b_q[SIZE-1] ^ sum[STEP];
        ovf_nxt = res_nxt[SIZE] ^ res_nxt[SIZE-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q          <= '0;
            b_q          <= '0;
            carry_q      <= 1'b0;
            sat_q        <= 1'b0;
            k_q          <= '0;
            result_q     <= '0;
            sat_result_q <= '0;
            overflow_q   <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            sat_q   <= saturate;
            k_q     <= '0;
        end else if (state == RUN) begin
            result_q <= res_nxt;
            carry_q  <= sum[STEP];
            k_q      <= k_q + KW'(1);
            if (last) begin
                overflow_q   <= ovf_nxt;
                sat_result_q <= sat_fn(res_nxt, sat_q);
            end
        end
    end

    assign result     = result_q;
    assign sat_result = sat_result_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_signed_addsub_serial.sv
// Directed bench for signed_addsub_serial: STEP=4 main instance plus STEP=1 and STEP=8 builds.
module tb_signed_addsub_serial;

    logic              clk;
    logic              rst;
    logic              in_valid, in_ready, sub, saturate, out_valid, out_ready, overflow;
    logic signed [7:0] a, b, sat_result;
    logic signed [8:0] result;

    logic              iv1, ir1, ov1, or1, ovf1;
    logic signed [7:0] sr1;
    logic signed [8:0] r1;
    logic              iv8, ir8, ov8, or8, ovf8;
    logic signed [7:0] sr8;
    logic signed [8:0] r8;

    int n_cmp  = 0;
    int n_fail = 0;

    signed_addsub_serial #(.SIZE(8), .STEP(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .sub(sub), .saturate(saturate), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .sat_result(sat_result), .overflow(overflow));

    signed_addsub_serial #(.SIZE(8), .STEP(1)) dut_s1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
        .sub(sub), .saturate(saturate), .out_valid(ov1), .out_ready(or1),
        .result(r1), .sat_result(sr1), .overflow(ovf1));

    signed_addsub_serial #(.SIZE(8), .STEP(8)) dut_s8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a), .b(b),
        .sub(sub), .saturate(saturate), .out_valid(ov8), .out_ready(or8),
        .result(r8), .sat_result(sr8), .overflow(ovf8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic s, input logic sat);
        a = av; b = bv; sub = s; saturate = sat; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        n_cmp++; if (result !== 9'h000) begin n_fail++; $display("FAIL rst_result got %h exp 000", result); end
        n_cmp++; if (sat_result !== 8'h00 || overflow !== 1'b0) begin n_fail++; $display("FAIL rst_sat_ovf got %h/%b exp 00/0", sat_result, overflow); end
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_overflow_add();
        int cyc;
        launch(8'h7F, 8'h01, 1'b0, 1'b0);
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL add_busy_in_ready got %b exp 0", in_ready); end
        wait_done(cyc);
        n_cmp++; if (cyc != 2) begin n_fail++; $display("FAIL add_latency got %0d exp 2", cyc); end
        n_cmp++; if (result !== 9'h080) begin n_fail++; $display("FAIL add_result got %h exp 080", result); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL add_ovf got %b exp 1", overflow); end
        n_cmp++; if (sat_result !== 8'h80) begin n_fail++; $display("FAIL add_wrap got %h exp 80", sat_result); end
        drain();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL add_drain got ov=%b ir=%b exp 0/1", out_valid, in_ready); end
        launch(8'h7F, 8'h01, 1'b0, 1'b1);
        wait_done(cyc);
        n_cmp++; if (sat_result !== 8'h7F) begin n_fail++; $display("FAIL add_sat got %h exp 7f", sat_result); end
        n_cmp++; if (result !== 9'h080) begin n_fail++; $display("FAIL add_sat_result got %h exp 080", result); end
        drain();
    endtask

    task automatic test_overflow_sub();
        int cyc;
        launch(8'h80, 8'h01, 1'b1, 1'b1);
        wait_done(cyc);
        n_cmp++; if (result !== 9'h17F) begin n_fail++; $display("FAIL sub_neg_result got %h exp 17f", result); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sub_neg_ovf got %b exp 1", overflow); end
        n_cmp++; if (sat_result !== 8'h80) begin n_fail++; $display("FAIL sub_neg_sat got %h exp 80", sat_result); end
        drain();
        launch(8'h00, 8'h80, 1'b1, 1'b1);
        wait_done(cyc);
        n_cmp++; if (result !== 9'h080) begin n_fail++; $display("FAIL sub_minb_result got %h exp 080", result); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sub_minb_ovf got %b exp 1", overflow); end
        n_cmp++; if (sat_result !== 8'h7F) begin n_fail++; $display("FAIL sub_minb_sat got %h exp 7f", sat_result); end
        drain();
    endtask

    task automatic test_no_overflow();
        int cyc;
        launch(8'hFB, 8'h03, 1'b0, 1'b0);
        wait_done(cyc);
        n_cmp++; if (result !== 9'h1FE) begin n_fail++; $display("FAIL neg_sum_result got %h exp 1fe", result); end
        n_cmp++; if (overflow !== 1'b0 || sat_result !== 8'hFE) begin n_fail++; $display("FAIL neg_sum_ovf_sat got %b/%h exp 0/fe", overflow, sat_result); end
        drain();
        launch(8'h05, 8'h05, 1'b1, 1'b0);
        wait_done(cyc);
        n_cmp++; if (result !== 9'h000) begin n_fail++; $display("FAIL zero_result got %h exp 000", result); end
        n_cmp++; if (overflow !== 1'b0 || sat_result !== 8'h00) begin n_fail++; $display("FAIL zero_ovf_sat got %b/%h exp 0/00", overflow, sat_result); end
        drain();
        launch(8'h10, 8'h20, 1'b0, 1'b1);
        wait_done(cyc);
        n_cmp++; if (result !== 9'h030 || sat_result !== 8'h30 || overflow !== 1'b0) begin n_fail++; $display("FAIL sat_inrange got %h/%h/%b exp 030/30/0", result, sat_result, overflow); end
        drain();
    endtask

    task automatic test_back_to_back();
        int cyc;
        launch(8'h12, 8'h34, 1'b0, 1'b0);
        wait_done(cyc);
        a = 8'h01; b = 8'h01; sub = 1'b0; saturate = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_%0d got ov=%b ir=%b exp 1/0", i, out_valid, in_ready); end
            n_cmp++; if (result !== 9'h046 || sat_result !== 8'h46 || overflow !== 1'b0) begin n_fail++; $display("FAIL bp_stable_%0d got %h/%h/%b exp 046/46/0", i, result, sat_result, overflow); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got ov=%b ir=%b exp 0/1", out_valid, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_accept got ir=%b exp 0", in_ready); end
        wait_done(cyc);
        n_cmp++; if (cyc != 2) begin n_fail++; $display("FAIL bp_next_latency got %0d exp 2", cyc); end
        n_cmp++; if (result !== 9'h002) begin n_fail++; $display("FAIL bp_next_result got %h exp 002", result); end
        drain();
    endtask

    task automatic test_async_reset();
        int cyc;
        int seen;
        launch(8'h7F, 8'h7F, 1'b0, 1'b1);
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ctrl got ov=%b ir=%b exp 0/1", out_valid, in_ready); end
        n_cmp++; if (result !== 9'h000 || sat_result !== 8'h00 || overflow !== 1'b0) begin n_fail++; $display("FAIL arst_data got %h/%h/%b exp 000/00/0", result, sat_result, overflow); end
        @(posedge clk); #2;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL arst_no_emit got %0d pulses exp 0", seen); end
        launch(8'h40, 8'h40, 1'b0, 1'b1);
        wait_done(cyc);
        n_cmp++; if (cyc != 2 || result !== 9'h080 || sat_result !== 8'h7F || overflow !== 1'b1) begin n_fail++; $display("FAIL arst_recover got lat=%0d %h/%h/%b exp 2 080/7f/1", cyc, result, sat_result, overflow); end
        drain();
    endtask

    task automatic test_step_builds();
        int lat1, lat8;
        a = 8'h80; b = 8'h80; sub = 1'b0; saturate = 1'b0;
        iv1 = 1'b1; iv8 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0; iv8 = 1'b0;
        lat1 = -1; lat8 = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (ov1 === 1'b1 && lat1 < 0) lat1 = c;
            if (ov8 === 1'b1 && lat8 < 0) lat8 = c;
        end
        n_cmp++; if (lat1 != 8) begin n_fail++; $display("FAIL step1_latency got %0d exp 8", lat1); end
        n_cmp++; if (lat8 != 1) begin n_fail++; $display("FAIL step8_latency got %0d exp 1", lat8); end
        n_cmp++; if (r1 !== 9'h100 || ovf1 !== 1'b1 || sr1 !== 8'h00) begin n_fail++; $display("FAIL step1_out got %h/%b/%h exp 100/1/00", r1, ovf1, sr1); end
        n_cmp++; if (r8 !== 9'h100 || ovf8 !== 1'b1 || sr8 !== 8'h00) begin n_fail++; $display("FAIL step8_out got %h/%b/%h exp 100/1/00", r8, ovf8, sr8); end
        or1 = 1'b1; or8 = 1'b1;
        @(posedge clk); #1;
        or1 = 1'b0; or8 = 1'b0;
        n_cmp++; if (ov1 !== 1'b0 || ov8 !== 1'b0 || ir1 !== 1'b1 || ir8 !== 1'b1) begin n_fail++; $display("FAIL step_drain got ov=%b%b ir=%b%b exp 00/11", ov1, ov8, ir1, ir8); end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0; saturate = 1'b0;
        iv1 = 1'b0; or1 = 1'b0; iv8 = 1'b0; or8 = 1'b0;
        #1;
        test_reset();
        test_overflow_add();
        test_overflow_sub();
        test_no_overflow();
        test_back_to_back();
        test_async_reset();
        test_step_builds();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
